// File: rtl/iterative_alu.sv
// Purpose: multi-cycle EX-stage ALU; logic/arith in one cycle, shifts one bit per cycle.
// Latency: 1 cycle for non-shift ops or shamt=0; shamt+1 cycles for shifts with shamt>=1.
// Backpressure: ready_o only in IDLE; result held in DONE until ready_i, then one IDLE cycle.
module iterative_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q,   acc_d;
    logic [SHW-1:0]     cnt_q,   cnt_d;
    logic [2:0]         op_q,    op_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic               zero_q,  zero_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;

    logic [SHW-1:0]     shamt;
    logic               is_shift;
    logic [WIDTH-1:0]   single_res;
    logic [WIDTH-1:0]   acc_shifted;

    assign shamt    = data2_i[SHW-1:0];
    assign is_shift = (ALUCtrl_i == OP_SLL) || (ALUCtrl_i == OP_SRL) || (ALUCtrl_i == OP_SRA);

    // Single-cycle result for the incoming operation; a shift reaching here has shamt=0.
    always_comb begin
        single_res = data1_i;
        case (ALUCtrl_i)
            OP_AND:  single_res = data1_i & data2_i;
            OP_ADD:  single_res = data1_i + data2_i;
            OP_SUB:  single_res = data1_i - data2_i;
            OP_OR:   single_res = data1_i | data2_i;
            OP_XOR:  single_res = data1_i ^ data2_i;
            default: single_res = data1_i;
        endcase
    end

    // One-bit step of the latched shift; SRA replicates the accumulator MSB.
    always_comb begin
        acc_shifted = acc_q;
        case (op_q)
            OP_SLL:  acc_shifted = {acc_q[WIDTH-2:0], 1'b0};
            OP_SRL:  acc_shifted = {1'b0, acc_q[WIDTH-1:1]};
            OP_SRA:  acc_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: acc_shifted = acc_q;
        endcase
    end

    // Next-state and datapath update; handshake outputs follow the next state only.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = data1_i;
                        cnt_d   = shamt;
                        op_d    = ALUCtrl_i;
                        state_d = S_SHIFT;
                    end else begin
                        data_d  = single_res;
                        zero_d  = (single_res == '0);
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = acc_shifted;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    data_d  = acc_shifted;
                    zero_d  = (acc_shifted == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    // State registers with synchronous active-low reset discarding any in-flight work.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_AND;
            data_q  <= '0;
            zero_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign zero_o  = zero_q;

endmodule

// File: doc/iterative_alu.md
# iterative_alu

Multi-cycle execute unit at the consumer end of the 3-bit ALU control code produced by the ALU control decoder. It latches two operands and an ALUCtrl code through a valid/ready handshake. Logic and arithmetic ops finish in one cycle; shifts run one bit per cycle. The result and a zero flag are held in an output register until the downstream stage accepts them. It sits in the EX stage and feeds the MEM/WB path and the branch comparator (zero flag for BEQ/BNE via SUB).

## Interface
- WIDTH, 32, operand/result width; must be a power of two ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (5 for WIDTH=32)

- clk_i  input  1  single clock; all state updates on rising edge
- rst_i  input  1  reset: synchronous, active-low
- valid_i  input  1  upstream presents an operation
- ready_o  output  1  unit can accept an operation this cycle
- ALUCtrl_i  input  3  operation code (encoding below)
- data1_i  input  WIDTH  operand A / shift source
- data2_i  input  WIDTH  operand B; bits [SHW-1:0] are the shift amount for shifts
- valid_o  output  1  data_o/zero_o hold a completed result
- ready_i  input  1  downstream accepts the result
- data_o  output  WIDTH  result
- zero_o  output  1  1 when data_o == 0

## Operation
- ALUCtrl encoding: 000 AND, 001 ADD, 010 SUB, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA. All 8 codes are legal.
- States: IDLE, SHIFT, DONE.
- IDLE: ready_o=1, valid_o=0. Accept occurs when valid_i && ready_o at a rising edge.
  - Non-shift op: compute result from the inputs, load data_o and zero_o, go to DONE.
  - Shift with shamt=data2_i[SHW-1:0]=0: data_o=data1_i, go to DONE.
  - Shift with shamt≥1: acc=data1_i, cnt=shamt, latch the op, go to SHIFT.
- SHIFT: ready_o=0, valid_o=0.
  - Each edge shifts acc by 1 bit: SLL fills 0 at LSB; SRL fills 0 at MSB; SRA replicates acc MSB.
  - Each edge decrements cnt. On the edge where cnt==1, write the shifted value to data_o and zero_o, and go to DONE.
- DONE: valid_o=1, ready_o=0. data_o and zero_o stay stable until the edge where ready_i=1, then go to IDLE.
- Arithmetic rules:
  - ADD/SUB are modulo 2^WIDTH; carry and overflow are discarded.
  - Bits of data2_i above SHW-1 are ignored for shifts.
- Inputs are sampled only at the accept edge. Later changes to data1_i, data2_i, ALUCtrl_i or valid_i have no effect on an operation in flight.
- zero_o is computed from the final result value and registered together with data_o.
- ready_o and valid_o are pure functions of state (Moore); neither depends combinationally on valid_i or ready_i.

## Timing
- Reset (rst_i=0 at an edge): state=IDLE, data_o=0, zero_o=0, valid_o=0, ready_o=1 from the next cycle. Reset applies in any state; an in-flight operation or an unconsumed result is discarded.
- Latency, from accept edge E to valid_o high:
  - Non-shift op, or shift with shamt=0: valid_o high in the cycle after E (1 cycle).
  - Shift with shamt=k≥1: valid_o high after edge E+k (k+1 cycles); worst case WIDTH cycles for shamt=WIDTH-1.
- If ready_i is already 1 when DONE is entered, the result is consumed on the next edge; DONE lasts a minimum of 1 cycle.
- Back-to-back throughput: one IDLE cycle is needed between the consume edge and the next accept, so 1-cycle ops issue every 2 cycles.
- ready_i=1 while not in DONE is ignored. valid_i=1 while ready_o=0 is ignored: the operation is not accepted, and upstream must keep valid_i high.

## Test plan
- Reset/idle: hold rst_i=0 for 2 edges, then release → ready_o=1, valid_o=0, data_o=0, zero_o=0.
- Arithmetic and zero flag:
  - ADD 0xFFFFFFFF+0x00000001 → data_o=0x00000000, zero_o=1, valid_o 1 cycle after accept.
  - SUB 5-7 → 0xFFFFFFFE, zero_o=0.
  - SUB 9-9 → zero_o=1.
- Logic ops: AND/OR/XOR on 0xF0F0A5A5 and 0x0FF0FFFF → 0x00F0A5A5 / 0xFFF0FFFF / 0xFF005A5A, each with 1-cycle latency.
- Shifts:
  - SRA 0x80000000 by 4 → 0xF8000000, valid_o exactly 5 cycles after accept.
  - SRL same operands → 0x08000000.
  - SLL 0x1 by 31 → 0x80000000 after 32 cycles.
  - SLL by data2_i=0x20 (shamt 0) → data_o=data1_i, 1-cycle latency.
- Handshake/backpressure:
  - Hold ready_i=0 for 10 cycles in DONE → data_o and valid_o stable, ready_o=0, and toggling valid_i/data1_i does not change data_o.
  - After ready_i=1: IDLE next cycle, and a new op is accepted on the following edge.
- Reset mid-operation: start SLL by 20, assert rst_i=0 at shift cycle 7 → next cycle IDLE, valid_o=0, data_o=0. A subsequent ADD 2+3 → 5.
